sha256_compress: RTL

Round engine and controller for the SHA-256 datapath, directly downstream of the `w_file` message-expansion stage. It drives `w_file`'s `init`/`next` strobes and consumes one schedule word W_t per cycle from `w_out` across 64 rounds. It holds working variables a–h and the chaining hash H0–H7, and presents the 256-bit digest after each 512-bit block. Multi-block messages are chained by clearing `first_block` on subsequent starts.

---
 rtl/sha256_pkg.sv | 60 ++++++
 rtl/sha256_round.sv | 27 ++
 rtl/sha256_compress.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 round constants, initial hash value, FSM encoding and round functions
// Contents:
//   state_t          controller states
//   K[0:63]          per-round additive constants
//   IV[0:7]          initial hash value H0..H7
//   big_sigma0/1     rotation mixes applied to a and e
//   ch / maj         bitwise choose and majority
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
// Ports:
//   work_in   in  256  {a,b,c,d,e,f,g,h}, a in [255:224]
//   k         in  32   round constant K_t
//   w         in  32   schedule word W_t
//   work_out  out 256  working variables after the round, same packing
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] work_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] work_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = work_in;

    // Five-operand sum: the longest path of the whole engine.
    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign work_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - SHA-256 block compression controller with working and chaining registers
// Ports:
//   clk          in   1    rising-edge clock
//   Reset        in   1    asynchronous active-low reset
//   start        in   1    begin a block, honoured only while ready
//   first_block  in   1    with start: 1 seeds H from IV, 0 chains from current H
//   w_in         in   32   W_t from the message-schedule stage, used during ROUND only
//   w_init       out  1    load strobe to the schedule stage (LOAD state)
//   w_next       out  1    advance strobe to the schedule stage (ROUND state)
//   ready        out  1    idle and able to accept start
//   done         out  1    single-cycle pulse after H has been updated
//   digest       out  256  {H0..H7}, H0 in [255:224]
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  logic         start,
    input  logic         first_block,
    input  logic [31:0]  w_in,
    output logic         w_init,
    output logic         w_next,
    output logic         ready,
    output logic         done,
    output logic [255:0] digest
);

    state_t       state_q, state_d;
    logic [5:0]   t_q;
    logic         first_q;
    logic [255:0] work_q;
    logic [255:0] hash_q;
    logic [255:0] round_out;
    logic [255:0] iv_vec;
    logic [255:0] hash_sum;

    always_comb begin
        iv_vec = '0;
        for (int i = 0; i < 8; i++) begin
            iv_vec[255 - 32*i -: 32] = IV[i];
        end
    end

    // Per-word feed-forward; each lane wraps independently at 32 bits.
    always_comb begin
        hash_sum = '0;
        for (int i = 0; i < 8; i++) begin
            hash_sum[255 - 32*i -: 32] = hash_q[255 - 32*i -: 32] + work_q[255 - 32*i -: 32];
        end
    end

    sha256_round u_round (
        .work_in  (work_q),
        .k        (K[t_q]),
        .w        (w_in),
        .work_out (round_out)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        w_init  = 1'b0;
        w_next  = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_init  = 1'b1;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                w_next = 1'b1;
                // Last round: the counter is about to wrap back to 0.
                if (t_q == 6'd63) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            first_q <= 1'b0;
            work_q  <= '0;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        first_q <= first_block;
                    end
                end
                ST_LOAD: begin
                    t_q <= '0;
                    if (first_q) begin
                        hash_q <= iv_vec;
                        work_q <= iv_vec;
                    end else begin
                        work_q <= hash_q;
                    end
                end
                ST_ROUND: begin
                    work_q <= round_out;
                    t_q    <= t_q + 6'd1;
                end
                ST_UPDATE: begin
                    hash_q <= hash_sum;
                end
                default: begin
                end
            endcase
        end
    end

    assign digest = hash_q;

endmodule
